// File: rtl/prog_loader_if.sv
// Byte-stream, CPU fetch and program-memory signals of the program loader.
// slave is the loader's view; master is the view of whatever drives it.
interface prog_loader_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 18
);
   logic              LOAD_REQ;
   logic [7:0]        BYTE_IN;
   logic              BYTE_VALID;
   logic              BYTE_READY;
   logic [ADDR_W-1:0] CPU_ADDR;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [DATA_W-1:0] MEM_WDATA;
   logic              MEM_WE;
   logic              CPU_RST;
   logic              LOAD_BUSY;
   logic              LOAD_DONE;
   logic              LOAD_ERR;
   logic [ADDR_W:0]   WORD_CNT;

   modport master (
      output LOAD_REQ, BYTE_IN, BYTE_VALID, CPU_ADDR,
      input  BYTE_READY, MEM_ADDR, MEM_WDATA, MEM_WE, CPU_RST,
             LOAD_BUSY, LOAD_DONE, LOAD_ERR, WORD_CNT
   );

   modport slave (
      input  LOAD_REQ, BYTE_IN, BYTE_VALID, CPU_ADDR,
      output BYTE_READY, MEM_ADDR, MEM_WDATA, MEM_WE, CPU_RST,
             LOAD_BUSY, LOAD_DONE, LOAD_ERR, WORD_CNT
   );
endinterface

// File: rtl/prog_loader.sv
// Program memory loader: streams a length/checksum-framed image into the 18-bit
// program memory while holding the CPU in reset, and muxes the memory address.
module prog_loader #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 18,
   parameter int TIMEOUT = 100000
) (
   input logic        CLK,
   input logic        RST,
   prog_loader_if.slave bus
);
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [ADDR_W:0]  MAX_N    = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [3:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2, S_WRITE, S_CSUM, S_ERROR
   } state_t;

   state_t            r_state;
   logic              r_ready;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata;
   logic              r_cpu_rst;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [ADDR_W:0]   r_wcnt;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_csum;
   logic [TMO_W-1:0]  r_tmo;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W-8:0] r_len_hi;
   logic [1:0]        r_b0;
   logic [7:0]        r_b1;

   logic              w_acc;
   logic              w_tmo_hit;
   logic [ADDR_W:0]   w_len;
   logic [ADDR_W:0]   w_wcnt_nx;

   assign w_acc     = bus.BYTE_VALID & r_ready;
   assign w_tmo_hit = r_ready & ~w_acc & (r_tmo == TMO_LAST);
   assign w_len     = {r_len_hi, bus.BYTE_IN};
   assign w_wcnt_nx = r_wcnt + (ADDR_W+1)'(1);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_ready   <= 1'b0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
         r_cpu_rst <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_wcnt    <= '0;
         r_addr    <= '0;
         r_csum    <= '0;
         r_tmo     <= '0;
      end else begin
         r_done <= 1'b0;
         r_we   <= 1'b0;
         // Idle-gap counter only runs while waiting on a byte
         if (r_ready) r_tmo <= w_acc ? '0 : r_tmo + TMO_W'(1);

         case (r_state)
            S_IDLE, S_ERROR: begin
               if (bus.LOAD_REQ) begin
                  r_state   <= S_LEN_HI;
                  r_ready   <= 1'b1;
                  r_cpu_rst <= 1'b1;
                  r_busy    <= 1'b1;
                  r_err     <= 1'b0;
                  r_wcnt    <= '0;
                  r_addr    <= '0;
                  r_csum    <= '0;
                  r_tmo     <= '0;
               end
            end
            S_LEN_HI: if (w_acc) begin
               r_len_hi <= bus.BYTE_IN[ADDR_W-8:0];
               r_state  <= S_LEN_LO;
            end
            S_LEN_LO: if (w_acc) begin
               r_len <= w_len;
               if (w_len == '0 || w_len > MAX_N) begin
                  r_state <= S_ERROR;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
               end else begin
                  r_state <= S_B0;
               end
            end
            S_B0: if (w_acc) begin
               r_b0    <= bus.BYTE_IN[1:0];
               r_csum  <= r_csum + bus.BYTE_IN;
               r_state <= S_B1;
            end
            S_B1: if (w_acc) begin
               r_b1    <= bus.BYTE_IN;
               r_csum  <= r_csum + bus.BYTE_IN;
               r_state <= S_B2;
            end
            S_B2: if (w_acc) begin
               r_wdata <= {r_b0, r_b1, bus.BYTE_IN};
               r_we    <= 1'b1;
               r_ready <= 1'b0;
               r_csum  <= r_csum + bus.BYTE_IN;
               r_state <= S_WRITE;
            end
            S_WRITE: begin
               r_addr  <= r_addr + ADDR_W'(1);
               r_wcnt  <= w_wcnt_nx;
               r_ready <= 1'b1;
               r_tmo   <= '0;
               r_state <= (w_wcnt_nx == r_len) ? S_CSUM : S_B0;
            end
            S_CSUM: if (w_acc) begin
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
               if (bus.BYTE_IN == r_csum) begin
                  r_state   <= S_IDLE;
                  r_cpu_rst <= 1'b0;
                  r_done    <= 1'b1;
               end else begin
                  r_state <= S_ERROR;
                  r_err   <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_tmo_hit) begin
            r_state <= S_ERROR;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_tmo   <= '0;
         end
      end
   end

   assign bus.BYTE_READY = r_ready;
   assign bus.MEM_ADDR   = r_busy ? r_addr : bus.CPU_ADDR;
   assign bus.MEM_WDATA  = r_wdata;
   assign bus.MEM_WE     = r_we;
   assign bus.CPU_RST    = r_cpu_rst;
   assign bus.LOAD_BUSY  = r_busy;
   assign bus.LOAD_DONE  = r_done;
   assign bus.LOAD_ERR   = r_err;
   assign bus.WORD_CNT   = r_wcnt;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected memory writes are queued by the
// stimulus and popped by a monitor on every MEM_WE cycle.
module tb_prog_loader;
   localparam int AW  = 10;
   localparam int DW  = 18;
   localparam int TMO = 50;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   prog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   prog_loader #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   wr_t  exp_q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   done_cnt = 0;
   logic hold     = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every write is matched against the next queued expectation
   always @(negedge CLK) begin
      wr_t e;
      if (bus.LOAD_DONE) done_cnt++;
      if (bus.MEM_WE) begin
         chk("ready_low_in_write", 32'(bus.BYTE_READY), 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr=0x%0h data=0x%0h required=no write",
                     bus.MEM_ADDR, bus.MEM_WDATA);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.MEM_ADDR), 32'(e.addr));
            chk("wr_data", 32'(bus.MEM_WDATA), 32'(e.data));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.BYTE_IN    = b;
      bus.BYTE_VALID = 1'b1;
      @(negedge CLK);
      while (!bus.BYTE_READY && n < 200) begin
         @(negedge CLK);
         n++;
      end
      chk("byte_ready_within_budget", 32'(bus.BYTE_READY), 32'd1);
      @(posedge CLK);
      #1;
      if (!hold) begin
         bus.BYTE_VALID = 1'b0;
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic word3(input logic [AW-1:0] a, input logic [7:0] b0, b1, b2,
                        input logic [DW-1:0] w);
      exp_q.push_back('{addr: a, data: w});
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
   endtask

   task automatic pulse_req();
      bus.LOAD_REQ = 1'b1;
      @(posedge CLK);
      #1;
      bus.LOAD_REQ = 1'b0;
   endtask

   task automatic settle();
      bus.BYTE_VALID = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
   endtask

   task automatic two_word_image(input logic [7:0] csum);
      send_byte(8'h00);
      send_byte(8'h02);
      word3(10'd0, 8'h01, 8'h23, 8'h45, 18'h12345);
      word3(10'd1, 8'h03, 8'hFF, 8'hFF, 18'h3FFFF);
      send_byte(csum);
      settle();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_byte_ready"}, 32'(bus.BYTE_READY), 32'd0);
      chk({tag, "_mem_we"},     32'(bus.MEM_WE),     32'd0);
      chk({tag, "_mem_wdata"},  32'(bus.MEM_WDATA),  32'd0);
      chk({tag, "_cpu_rst"},    32'(bus.CPU_RST),    32'd0);
      chk({tag, "_load_busy"},  32'(bus.LOAD_BUSY),  32'd0);
      chk({tag, "_load_done"},  32'(bus.LOAD_DONE),  32'd0);
      chk({tag, "_load_err"},   32'(bus.LOAD_ERR),   32'd0);
      chk({tag, "_word_cnt"},   32'(bus.WORD_CNT),   32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      logic [7:0]    cs;
      logic [DW-1:0] w;
      logic [7:0]    b0;

      bus.LOAD_REQ   = 1'b0;
      bus.BYTE_IN    = 8'h00;
      bus.BYTE_VALID = 1'b0;
      bus.CPU_ADDR   = '0;
      repeat (3) @(posedge CLK);
      #1;
      check_reset_outputs("reset");
      RST = 1'b0;
      @(posedge CLK);
      #1;

      // Happy path
      pulse_req();
      chk("start_cpu_rst", 32'(bus.CPU_RST), 32'd1);
      chk("start_busy", 32'(bus.LOAD_BUSY), 32'd1);
      d0 = done_cnt;
      two_word_image(8'h6A);
      chk("happy_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("happy_cpu_rst", 32'(bus.CPU_RST), 32'd0);
      chk("happy_busy", 32'(bus.LOAD_BUSY), 32'd0);
      chk("happy_word_cnt", 32'(bus.WORD_CNT), 32'd2);
      chk("happy_err", 32'(bus.LOAD_ERR), 32'd0);
      chk("happy_queue_drained", 32'(exp_q.size()), 32'd0);

      // Bad checksum, then restart from ERROR
      pulse_req();
      d0 = done_cnt;
      two_word_image(8'h6B);
      chk("badcs_done_pulses", 32'(done_cnt - d0), 32'd0);
      chk("badcs_err", 32'(bus.LOAD_ERR), 32'd1);
      chk("badcs_cpu_rst", 32'(bus.CPU_RST), 32'd1);
      chk("badcs_busy", 32'(bus.LOAD_BUSY), 32'd0);
      chk("badcs_ready", 32'(bus.BYTE_READY), 32'd0);
      chk("badcs_word_cnt", 32'(bus.WORD_CNT), 32'd2);
      chk("badcs_queue_drained", 32'(exp_q.size()), 32'd0);
      bus.CPU_ADDR = 10'h155;
      #1;
      chk("error_passthrough", 32'(bus.MEM_ADDR), 32'h155);
      @(posedge CLK);
      #1;
      pulse_req();
      chk("restart_err_cleared", 32'(bus.LOAD_ERR), 32'd0);
      chk("restart_busy", 32'(bus.LOAD_BUSY), 32'd1);
      chk("restart_word_cnt", 32'(bus.WORD_CNT), 32'd0);
      d0 = done_cnt;
      two_word_image(8'h6A);
      chk("restart_done_pulses", 32'(done_cnt - d0), 32'd1);

      // Length bounds: 0 and 1025 words
      pulse_req();
      send_byte(8'h00);
      send_byte(8'h00);
      chk("len0_err", 32'(bus.LOAD_ERR), 32'd1);
      chk("len0_ready", 32'(bus.BYTE_READY), 32'd0);
      chk("len0_busy", 32'(bus.LOAD_BUSY), 32'd0);
      pulse_req();
      send_byte(8'h04);
      send_byte(8'h01);
      chk("len1025_err", 32'(bus.LOAD_ERR), 32'd1);
      chk("len1025_cpu_rst", 32'(bus.CPU_RST), 32'd1);

      // Full 1024-word image with BYTE_VALID held high throughout
      pulse_req();
      hold = 1'b1;
      send_byte(8'h04);
      send_byte(8'h00);
      cs = 8'h00;
      for (int i = 0; i < 1024; i++) begin
         w  = 18'(i * 263) ^ 18'h2A5A5;
         b0 = {6'(i), w[17:16]};
         cs = cs + b0 + w[15:8] + w[7:0];
         word3(10'(i), b0, w[15:8], w[7:0], w);
      end
      d0 = done_cnt;
      send_byte(cs);
      hold = 1'b0;
      settle();
      chk("full_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("full_word_cnt", 32'(bus.WORD_CNT), 32'd1024);
      chk("full_err", 32'(bus.LOAD_ERR), 32'd0);
      chk("full_queue_drained", 32'(exp_q.size()), 32'd0);

      // Timeout after B1 of word 0
      pulse_req();
      hold = 1'b1;
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'h23);
      bus.BYTE_VALID = 1'b0;
      hold = 1'b0;
      repeat (TMO - 1) @(posedge CLK);
      #1;
      chk("tmo_err_before", 32'(bus.LOAD_ERR), 32'd0);
      @(posedge CLK);
      #1;
      chk("tmo_err_at_limit", 32'(bus.LOAD_ERR), 32'd1);
      chk("tmo_cpu_rst", 32'(bus.CPU_RST), 32'd1);
      chk("tmo_busy", 32'(bus.LOAD_BUSY), 32'd0);
      chk("tmo_word_cnt", 32'(bus.WORD_CNT), 32'd0);

      // LOAD_REQ mid-load must be ignored
      pulse_req();
      hold = 1'b1;
      send_byte(8'h00);
      send_byte(8'h01);
      bus.BYTE_VALID = 1'b0;
      hold = 1'b0;
      pulse_req();
      chk("midreq_busy", 32'(bus.LOAD_BUSY), 32'd1);
      d0 = done_cnt;
      word3(10'd0, 8'hFD, 8'h00, 8'h01, 18'h10001);
      send_byte(8'hFE);
      settle();
      chk("midreq_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("midreq_word_cnt", 32'(bus.WORD_CNT), 32'd1);

      // IDLE address pass-through sweep
      for (int a = 0; a < 1024; a++) begin
         bus.CPU_ADDR = 10'(a);
         #1;
         chk("idle_passthrough", 32'(bus.MEM_ADDR), 32'(a));
      end
      @(posedge CLK);
      #1;

      // Reset in the middle of a word
      pulse_req();
      hold = 1'b1;
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h01);
      bus.BYTE_VALID = 1'b0;
      hold = 1'b0;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      check_reset_outputs("midrst");
      bus.CPU_ADDR = 10'h2AA;
      #1;
      chk("midrst_passthrough", 32'(bus.MEM_ADDR), 32'h2AA);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      pulse_req();
      d0 = done_cnt;
      two_word_image(8'h6A);
      chk("postrst_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("postrst_word_cnt", 32'(bus.WORD_CNT), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
